// File: rtl/csa_accum_ctrl.sv
// Carry-save accumulation controller: reduces a job of 0..M operands into a
// redundant sum/carry pair, then resolves once and offers the binary total.
module csa_accum_ctrl #(
  parameter int N  = 6,
  parameter int M  = 8,
  parameter int CW = $clog2(M + 1),
  parameter int W  = N + $clog2(M)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] num_ops,
  input  logic          op_valid,
  input  logic [N-1:0]  op_data,
  output logic          op_ready,
  output logic          res_valid,
  output logic [W-1:0]  res_data,
  input  logic          res_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_sum;
  logic [W-1:0]  r_carry;
  logic [W-1:0]  r_res;
  logic [CW-1:0] r_remain;
  logic          r_op_ready;
  logic          r_res_valid;
  logic          r_busy;

  logic [W-1:0]  w_x;
  logic [W-1:0]  w_maj;
  logic [W-1:0]  w_carry_next;
  logic [CW-1:0] w_count;
  logic          w_accept;

  assign w_x          = W'(op_data);
  assign w_maj        = (r_sum & r_carry) | (r_sum & w_x) | (r_carry & w_x);
  assign w_carry_next = {w_maj[W-2:0], 1'b0};
  assign w_count      = (num_ops > CW'(M)) ? CW'(M) : num_ops;
  // Handshake uses the registered ready, so no input ever reaches an output.
  assign w_accept     = op_valid && r_op_ready;

  // NOTE: all state below is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sum       <= '0;
      r_carry     <= '0;
      r_res       <= '0;
      r_remain    <= '0;
      r_op_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sum    <= '0;
            r_carry  <= '0;
            r_remain <= w_count;
            r_busy   <= 1'b1;
            if (w_count != '0) begin
              r_state    <= S_ACCUM;
              r_op_ready <= 1'b1;
            end else begin
              r_state <= S_RESOLVE;
            end
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_sum    <= r_sum ^ r_carry ^ w_x;
            r_carry  <= w_carry_next;
            r_remain <= r_remain - 1'b1;
            if (r_remain == CW'(1)) begin
              r_state    <= S_RESOLVE;
              r_op_ready <= 1'b0;
            end
          end
        end
        S_RESOLVE: begin
          r_res       <= r_sum + r_carry;
          r_res_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_op_ready  <= 1'b0;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign op_ready  = r_op_ready;
  assign res_valid = r_res_valid;
  assign res_data  = r_res;
  assign busy      = r_busy;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Self-checking bench for csa_accum_ctrl: directed vector table, stall and
// reset-abort sequences, and a randomized job regression against a running sum.
module tb_csa_accum_ctrl;

  localparam int N  = 6;
  localparam int M  = 8;
  localparam int CW = $clog2(M + 1);
  localparam int W  = N + $clog2(M);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_ops;
  logic          op_valid;
  logic [N-1:0]  op_data;
  logic          op_ready;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic          res_ready;
  logic          busy;

  int n_checks;
  int n_fail;

  csa_accum_ctrl #(.N(N), .M(M), .CW(CW), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_ops  (num_ops),
    .op_valid (op_valid),
    .op_data  (op_data),
    .op_ready (op_ready),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_ready(res_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       n;
    logic [7:0][5:0]  ops;
    logic [8:0]       exp_res;
    logic [3:0]       exp_acc;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drives one job from start to result handshake. gap < 0 picks a random
  // 0..3 cycle valid gap after every accept; rdelay is the number of DONE
  // cycles res_ready stays low.
  task automatic run_job(input string tag, input logic [3:0] n, input logic [7:0][5:0] ops,
                         input int gap, input int rdelay, input bit start_in_done,
                         input logic [8:0] exp_res, input int exp_acc);
    int cyc, idx, gcnt, last_acc, first_rv, dcnt, acc;
    logic [8:0] model, held, inv, res;
    bit done, ready_in_done, unstable, just_acc;
    cyc = 0; idx = 0; gcnt = 0; last_acc = 0; first_rv = -1; dcnt = 0; acc = 0;
    model = '0; held = '0; inv = '0; res = '0;
    done = 0; ready_in_done = 0; unstable = 0; just_acc = 0;
    start = 1'b1; num_ops = n; op_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    check({tag, " op_ready_after_start"}, 32'(op_ready), 32'(n != 4'd0));
    while (!done && cyc < 300) begin
      if (just_acc) begin
        inv = dut.r_sum + dut.r_carry;
        check({tag, " invariant"}, 32'(inv), 32'(model));
        just_acc = 0;
      end
      op_valid  = (gcnt == 0);
      op_data   = ops[idx % 8];
      res_ready = res_valid && (dcnt >= rdelay);
      start     = start_in_done && res_valid && !res_ready;
      num_ops   = 4'd3;
      @(negedge clk);
      cyc++;
      if (op_valid && op_ready) begin
        acc++;
        model    = model + 9'(op_data);
        idx++;
        last_acc = cyc;
        just_acc = 1;
        gcnt     = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      end else if (gcnt > 0) begin
        gcnt--;
      end
      if (res_valid) begin
        if (first_rv < 0) begin
          first_rv = cyc;
          held     = res_data;
        end else if (res_data !== held) begin
          unstable = 1;
        end
        if (op_ready) ready_in_done = 1;
        dcnt++;
        if (res_ready) begin
          done = 1;
          res  = res_data;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " res_data"}, 32'(res), 32'(exp_res));
    check({tag, " accepts"}, 32'(acc), 32'(exp_acc));
    check({tag, " latency"}, 32'(first_rv - last_acc), 32'd2);
    check({tag, " res_stable"}, 32'(unstable), 32'd0);
    check({tag, " no_ready_in_done"}, 32'(ready_in_done), 32'd0);
    check({tag, " done_cycles"}, 32'(dcnt), 32'(rdelay + 1));
    check({tag, " busy_after_handshake"}, 32'(busy), 32'd0);
    check({tag, " res_valid_after_handshake"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    logic [7:0][5:0] r_ops;
    logic [3:0]      r_n;
    logic [8:0]      r_exp;
    logic [8:0]      part;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{n: 4'd3,  ops: {30'd0, 6'd63, 6'd10, 6'd5}, exp_res: 9'd78,  exp_acc: 4'd3};
    vecs[1] = '{n: 4'd8,  ops: {8{6'd63}},                  exp_res: 9'd504, exp_acc: 4'd8};
    vecs[2] = '{n: 4'd15, ops: {8{6'd63}},                  exp_res: 9'd504, exp_acc: 4'd8};
    vecs[3] = '{n: 4'd0,  ops: {8{6'd21}},                  exp_res: 9'd0,   exp_acc: 4'd0};
    vecs[4] = '{n: 4'd1,  ops: {42'd0, 6'd1},               exp_res: 9'd1,   exp_acc: 4'd1};
    vecs[5] = '{n: 4'd2,  ops: {36'd0, 6'd1, 6'd63},        exp_res: 9'd64,  exp_acc: 4'd2};
    vecs[6] = '{n: 4'd5,  ops: {18'd0, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}, exp_res: 9'd15, exp_acc: 4'd5};

    rst_n = 1'b0; start = 1'b0; num_ops = '0; op_valid = 1'b0; op_data = '0; res_ready = 1'b0;
    #12;
    check("reset op_ready", 32'(op_ready), 32'd0);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset res_data", 32'(res_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_job($sformatf("vec%0d", i), vecs[i].n, vecs[i].ops, 0, 0, 1'b0,
              vecs[i].exp_res, int'(vecs[i].exp_acc));

    // Stalled operands, stalled result port, and a start pulse during DONE.
    run_job("stall", 4'd4, {24'd0, 6'd8, 6'd4, 6'd2, 6'd1}, 2, 5, 1'b1, 9'd15, 4);

    // Abort a job part-way with an asynchronous reset between edges.
    start = 1'b1; num_ops = 4'd4;
    @(posedge clk); #1;
    start = 1'b0; op_valid = 1'b1; op_data = 6'd20;
    @(posedge clk); #1;
    op_data = 6'd30;
    @(posedge clk); #1;
    op_valid = 1'b0;
    part = dut.r_sum + dut.r_carry;
    check("abort partial_sum", 32'(part), 32'd50);
    check("abort busy_before_reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort op_ready", 32'(op_ready), 32'd0);
    check("abort res_valid", 32'(res_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort res_data", 32'(res_data), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_job("after_abort", 4'd2, {36'd0, 6'd9, 6'd7}, 0, 0, 1'b0, 9'd16, 2);

    for (int j = 0; j < 1000; j++) begin
      r_n = 4'($urandom_range(0, M));
      r_exp = '0;
      for (int k = 0; k < 8; k++) begin
        r_ops[k] = 6'($urandom);
        if (k < int'(r_n)) r_exp = r_exp + 9'(r_ops[k]);
      end
      run_job($sformatf("rand%0d", j), r_n, r_ops, -1, int'($urandom_range(0, 3)), 1'b0,
              r_exp, int'(r_n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_accum_ctrl.md
# csa_accum_ctrl

Sequencing controller for the team's carry-save adder datapath. It accepts a job of 0..M operands over a valid/ready stream and reduces each one into a redundant sum/carry register pair with one 3:2 carry-save step per accepted operand. It then performs a single carry-propagate resolve and presents the binary total on a valid/ready result port. It sits between an operand producer (e.g. a multi-operand summation or MAC front end) and any consumer that needs a non-redundant result.

## Interface
- N, 6: operand width in bits.
- M, 8: maximum operands per job; power of two, ≥2.
- CW, $clog2(M+1): width of num_ops.
- W, N+$clog2(M): accumulator/result width; M operands of 2^N−1 never overflow.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- num_ops  in  CW  operand count for the job, sampled with start; values >M are treated as M.
- op_valid  in  1  operand valid.
- op_data  in  N  operand, zero-extended to W.
- op_ready  out  1  high only in ACCUM.
- res_valid  out  1  result valid; high only in DONE.
- res_data  out  W  resolved total; held stable while res_valid && !res_ready.
- res_ready  in  1  result accepted.
- busy  out  1  high in every state except IDLE.

## Operation
- Registers: sum_r[W], carry_r[W], remain[CW], state, res_r[W].
- IDLE: on start, clear sum_r/carry_r and load remain = min(num_ops, M). Next state is ACCUM if remain > 0, else RESOLVE.
- ACCUM: each accept (op_valid && op_ready) applies one CSA step with x = zero-extended op_data:
  - sum_r ← sum_r ^ carry_r ^ x
  - carry_r ← ((sum_r&carry_r) | (sum_r&x) | (carry_r&x)) << 1, truncated to W
  - remain decrements by 1.
  - The accept with remain == 1 moves the state to RESOLVE.
  - Cycles without an accept hold all state.
- RESOLVE: res_r ← (sum_r + carry_r) mod 2^W; next state is DONE.
- DONE: res_valid = 1. On res_ready, go to IDLE.
- start outside IDLE is ignored. An op_valid outside ACCUM is not accepted (op_ready = 0).
- An invariant holds throughout ACCUM: sum_r + carry_r ≡ the sum of accepted operands (mod 2^W).

## Timing
- Reset (asynchronous assert, synchronous-clean deassert): state = IDLE; sum_r, carry_r, remain and res_r = 0; op_ready = res_valid = busy = 0; res_data = 0.
- The outputs op_ready, res_valid, busy and res_data are decoded from registered state only. There is no combinational path from any input to any output.
- start at edge t makes busy = 1 and, if num_ops > 0, op_ready = 1 from cycle t+1.
- Throughput: one operand per cycle when op_valid is held high.
- Latency: the last operand is accepted at edge t. State is RESOLVE in cycle t+1, and res_valid = 1 from edge t+2 (2 cycles).
- num_ops = 0: start at edge t gives res_valid = 1 with res_data = 0 from edge t+2.
- When res_ready is high in the first DONE cycle, that cycle completes the handshake. IDLE follows on the next edge, and a new start is accepted one cycle after that, so there is a minimum 1-cycle IDLE gap.
- Back-to-back jobs: job latency = 3 + num_ops cycles (start→IDLE) with no stalls.
- Reset asserted in any state aborts the job immediately, with no partial result. The first start after release begins a fresh job.

## Test plan
- Basic sum, N=6, M=8: start with num_ops=3, ops 5, 10, 63 on consecutive cycles. Required: res_data = 78, res_valid rises exactly 2 cycles after the 63 is accepted, busy falls after the res_ready handshake.
- Full-scale: num_ops=8, all ops = 63. Required: res_data = 504 (no wrap, W=9). Also num_ops=15 (>M) with eight ops of 63: exactly 8 accepts, op_ready = 0 afterwards, res_data = 504.
- Zero-length job: start with num_ops=0. Required: op_ready never asserts, res_valid = 1 with res_data = 0 two cycles after start.
- Stalls: ops 1, 2, 4, 8 (num_ops=4) with op_valid low 2 cycles between each, and res_ready low for 5 cycles in DONE. Required:
  - only 4 accepts occur;
  - res_data = 15, held constant while stalled;
  - op_ready = 0 throughout DONE;
  - a start pulse during DONE is ignored.
- Reset mid-job: num_ops=4, accept 20 and 30, then pull rst_n low asynchronously between edges. Required: all outputs are 0 immediately. After release, start with num_ops=2 and ops 7, 9: res_data = 16, with no residue from the aborted job.
- Random regression: 1000 jobs with random num_ops 0..M, random operands and random valid/ready gaps. Required: res_data equals the reference sum every job, and the invariant sum_r + carry_r = running sum is checked after every accept.
